// File: rtl/game_timer_ctrl.sv
// ============================================================================
// game_timer_ctrl : MM:SS countdown controller driven by an upstream tick
// divider, with start/pause/clear edge controls.  Rev 1.0
// ============================================================================
`default_nettype none

module game_timer_ctrl #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tickIn,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic [5:0] limitMin,
   output logic       divEnable,
   output logic       divClear,
   output logic [2:0] minTens,
   output logic [3:0] minOnes,
   output logic [2:0] secTens,
   output logic [3:0] secOnes,
   output logic       running,
   output logic       expired,
   output logic       timeoutPulse
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_PAUSE   = 2'b10,
      ST_EXPIRED = 2'b11
   } state_t;

   localparam logic [7:0] C_SUB_LAST = 8'(TICKS_PER_SEC - 1);

   state_t     state_q;
   logic [7:0] sub_tick_q;
   logic [2:0] min_tens_q;
   logic [3:0] min_ones_q;
   logic [2:0] sec_tens_q;
   logic [3:0] sec_ones_q;
   logic       start_prev_q;
   logic       pause_prev_q;
   logic       clear_prev_q;
   logic       armed_q;
   logic       div_clear_q;
   logic       timeout_q;
   logic       running_q;
   logic       expired_q;

   logic       w_start_edge;
   logic       w_pause_edge;
   logic       w_clear_edge;
   logic       w_last_sec;
   logic [5:0] w_lim;
   logic [2:0] w_lim_tens;
   logic [3:0] w_lim_ones;
   logic [2:0] min_tens_d;
   logic [3:0] min_ones_d;
   logic [2:0] sec_tens_d;
   logic [3:0] sec_ones_d;

   // armed_q stays low for the first cycle after reset release so that a
   // level already high at release is absorbed into prev, not seen as an edge.
   assign w_start_edge = start & ~start_prev_q & armed_q;
   assign w_pause_edge = pause & ~pause_prev_q & armed_q;
   assign w_clear_edge = clear & ~clear_prev_q & armed_q;

   assign w_last_sec = (min_tens_q == 3'd0) && (min_ones_q == 4'd0) &&
                       (sec_tens_q == 3'd0) && (sec_ones_q == 4'd1);

   assign w_lim = (limitMin > 6'd59) ? 6'd59 : limitMin;

   // Binary minutes to BCD; ones digit is computed modulo 16 (e.g. 30 -> 14).
   always_comb begin
      w_lim_tens = 3'd0;
      w_lim_ones = w_lim[3:0];
      if (w_lim >= 6'd50) begin
         w_lim_tens = 3'd5;
         w_lim_ones = w_lim[3:0] - 4'd2;
      end else if (w_lim >= 6'd40) begin
         w_lim_tens = 3'd4;
         w_lim_ones = w_lim[3:0] - 4'd8;
      end else if (w_lim >= 6'd30) begin
         w_lim_tens = 3'd3;
         w_lim_ones = w_lim[3:0] - 4'd14;
      end else if (w_lim >= 6'd20) begin
         w_lim_tens = 3'd2;
         w_lim_ones = w_lim[3:0] - 4'd4;
      end else if (w_lim >= 6'd10) begin
         w_lim_tens = 3'd1;
         w_lim_ones = w_lim[3:0] - 4'd10;
      end
   end

   always_comb begin
      min_tens_d = min_tens_q;
      min_ones_d = min_ones_q;
      sec_tens_d = sec_tens_q;
      sec_ones_d = sec_ones_q - 4'd1;
      if (sec_ones_q == 4'd0) begin
         sec_ones_d = 4'd9;
         sec_tens_d = sec_tens_q - 3'd1;
         if (sec_tens_q == 3'd0) begin
            sec_tens_d = 3'd5;
            min_ones_d = min_ones_q - 4'd1;
            if (min_ones_q == 4'd0) begin
               min_ones_d = 4'd9;
               min_tens_d = min_tens_q - 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         sub_tick_q   <= 8'd0;
         min_tens_q   <= 3'd0;
         min_ones_q   <= 4'd0;
         sec_tens_q   <= 3'd0;
         sec_ones_q   <= 4'd0;
         start_prev_q <= 1'b0;
         pause_prev_q <= 1'b0;
         clear_prev_q <= 1'b0;
         armed_q      <= 1'b0;
         div_clear_q  <= 1'b0;
         timeout_q    <= 1'b0;
         running_q    <= 1'b0;
         expired_q    <= 1'b0;
      end else begin
         start_prev_q <= start;
         pause_prev_q <= pause;
         clear_prev_q <= clear;
         armed_q      <= 1'b1;
         div_clear_q  <= 1'b0;
         timeout_q    <= 1'b0;
         if (w_clear_edge) begin
            state_q     <= ST_IDLE;
            sub_tick_q  <= 8'd0;
            min_tens_q  <= 3'd0;
            min_ones_q  <= 4'd0;
            sec_tens_q  <= 3'd0;
            sec_ones_q  <= 4'd0;
            div_clear_q <= 1'b1;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (w_start_edge) begin
                     sub_tick_q  <= 8'd0;
                     min_tens_q  <= w_lim_tens;
                     min_ones_q  <= w_lim_ones;
                     sec_tens_q  <= 3'd0;
                     sec_ones_q  <= 4'd0;
                     div_clear_q <= 1'b1;
                     if (w_lim == 6'd0) begin
                        state_q   <= ST_EXPIRED;
                        timeout_q <= 1'b1;
                        expired_q <= 1'b1;
                     end else begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                     end
                  end
               end
               ST_RUN: begin
                  if (w_pause_edge) begin
                     state_q   <= ST_PAUSE;
                     running_q <= 1'b0;
                  end else if (tickIn) begin
                     if (sub_tick_q == C_SUB_LAST) begin
                        sub_tick_q <= 8'd0;
                        min_tens_q <= min_tens_d;
                        min_ones_q <= min_ones_d;
                        sec_tens_q <= sec_tens_d;
                        sec_ones_q <= sec_ones_d;
                        if (w_last_sec) begin
                           state_q   <= ST_EXPIRED;
                           timeout_q <= 1'b1;
                           running_q <= 1'b0;
                           expired_q <= 1'b1;
                        end
                     end else begin
                        sub_tick_q <= sub_tick_q + 8'd1;
                     end
                  end
               end
               ST_PAUSE: begin
                  if (w_start_edge || w_pause_edge) begin
                     state_q   <= ST_RUN;
                     running_q <= 1'b1;
                  end
               end
               ST_EXPIRED: begin
               end
            endcase
         end
      end
   end

   assign divEnable    = running_q;
   assign divClear     = div_clear_q;
   assign minTens      = min_tens_q;
   assign minOnes      = min_ones_q;
   assign secTens      = sec_tens_q;
   assign secOnes      = sec_ones_q;
   assign running      = running_q;
   assign expired      = expired_q;
   assign timeoutPulse = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
// ============================================================================
// tb_game_timer_ctrl : directed plus randomized bench against a seconds-based
// reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_game_timer_ctrl;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tickIn = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       clear = 1'b0;
   logic [5:0] limitMin = 6'd0;
   logic       divEnable, divClear, running, expired, timeoutPulse;
   logic [2:0] minTens, secTens;
   logic [3:0] minOnes, secOnes;

   game_timer_ctrl #(.TICKS_PER_SEC(T)) dut (
      .clk(clk), .rst(rst), .tickIn(tickIn), .start(start), .pause(pause),
      .clear(clear), .limitMin(limitMin), .divEnable(divEnable),
      .divClear(divClear), .minTens(minTens), .minOnes(minOnes),
      .secTens(secTens), .secOnes(secOnes), .running(running),
      .expired(expired), .timeoutPulse(timeoutPulse)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: mode 0 idle, 1 run, 2 pause, 3 expired; time in seconds.
   int m_mode, m_secs, m_sub, m_divclr, m_tmo;
   bit p_st, p_pa, p_cl, m_armed;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_mode = 0; m_secs = 0; m_sub = 0; m_divclr = 0; m_tmo = 0;
      p_st = 0; p_pa = 0; p_cl = 0; m_armed = 0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit p, input bit c, input int lim);
      bit se, pe, ce;
      int l;
      se = m_armed && s && !p_st;
      pe = m_armed && p && !p_pa;
      ce = m_armed && c && !p_cl;
      p_st = s; p_pa = p; p_cl = c; m_armed = 1;
      m_divclr = 0; m_tmo = 0;
      if (ce) begin
         m_mode = 0; m_secs = 0; m_sub = 0; m_divclr = 1;
      end else if (m_mode == 0) begin
         if (se) begin
            l = (lim > 59) ? 59 : lim;
            m_secs = l * 60; m_sub = 0; m_divclr = 1;
            if (l == 0) begin m_mode = 3; m_tmo = 1; end
            else m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (pe) m_mode = 2;
         else if (t) begin
            m_sub++;
            if (m_sub == T) begin
               m_sub = 0;
               m_secs--;
               if (m_secs == 0) begin m_mode = 3; m_tmo = 1; end
            end
         end
      end else if (m_mode == 2) begin
         if (se || pe) m_mode = 1;
      end
   endtask

   task automatic check_all();
      chk("minTens", minTens, (m_secs / 60) / 10);
      chk("minOnes", minOnes, (m_secs / 60) % 10);
      chk("secTens", secTens, (m_secs % 60) / 10);
      chk("secOnes", secOnes, m_secs % 10);
      chk("running", running, m_mode == 1);
      chk("divEnable", divEnable, m_mode == 1);
      chk("expired", expired, m_mode == 3);
      chk("divClear", divClear, m_divclr);
      chk("timeoutPulse", timeoutPulse, m_tmo);
   endtask

   task automatic step(input bit t, input bit s, input bit p, input bit c, input int lim);
      @(negedge clk);
      tickIn = t; start = s; pause = p; clear = c; limitMin = 6'(lim);
      @(posedge clk);
      model_step(t, s, p, c, lim);
      #1 check_all();
   endtask

   initial begin
      bit rs, rp, rc, rt;
      int rl;
      m_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk) rst = 1'b1;
      step(0, 0, 0, 0, 0);

      // 01:00 then one second of ticks
      step(0, 1, 0, 0, 1);
      chk("start_divclr", divClear, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
      chk("t59_secTens", secTens, 5);
      chk("t59_secOnes", secOnes, 9);
      chk("t59_minOnes", minOnes, 0);
      for (int i = 0; i < 236; i++) step(1, 0, 0, 0, 1);
      chk("exp_flag", expired, 1);
      chk("exp_pulse", timeoutPulse, 1);
      step(1, 1, 1, 0, 1);
      chk("exp_pulse_once", timeoutPulse, 0);

      // 10:00 -> 09:59 with full borrow chain
      step(0, 0, 0, 1, 10);
      step(0, 0, 0, 0, 10);
      step(0, 1, 0, 0, 10);
      chk("ld10_minTens", minTens, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 10);
      chk("b_minTens", minTens, 0);
      chk("b_minOnes", minOnes, 9);
      chk("b_secTens", secTens, 5);
      chk("b_secOnes", secOnes, 9);

      // pause with coincident tick, ticks ignored, resume keeps subTick
      step(1, 0, 0, 0, 10);
      step(1, 0, 0, 0, 10);
      step(1, 0, 1, 0, 10);
      chk("paused_run", running, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 10);
      chk("paused_hold", secOnes, 9);
      step(0, 0, 1, 0, 10);
      chk("resumed", running, 1);
      step(1, 0, 0, 0, 10);
      chk("resume_sub3", secOnes, 9);
      step(1, 0, 0, 0, 10);
      chk("resume_wrap", secOnes, 8);

      // limit clamp and zero limit
      step(0, 0, 0, 1, 63);
      step(0, 0, 0, 0, 63);
      step(0, 1, 0, 0, 63);
      chk("clamp_minTens", minTens, 5);
      chk("clamp_minOnes", minOnes, 9);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("zero_expired", expired, 1);
      chk("zero_pulse", timeoutPulse, 1);

      // clear + start together in RUN
      step(0, 0, 0, 1, 5);
      step(0, 0, 0, 0, 5);
      step(0, 1, 0, 0, 5);
      step(0, 0, 0, 0, 5);
      step(0, 1, 0, 1, 5);
      chk("cs_divclr", divClear, 1);
      chk("cs_running", running, 0);
      step(0, 1, 0, 0, 5);
      chk("held_start", running, 0);

      // asynchronous reset mid-run; start held high across release
      step(0, 0, 0, 0, 2);
      step(0, 1, 0, 0, 2);
      for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 2);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 m_reset();
      check_all();
      chk("arst_running", running, 0);
      @(negedge clk) rst = 1'b1;
      step(0, 1, 0, 0, 2);
      step(0, 1, 0, 0, 2);
      chk("rel_no_edge", running, 0);

      // randomized traffic
      rs = 1; rp = 0; rc = 0; rl = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) rs = ~rs;
         if ($urandom_range(0, 29) == 0) rp = ~rp;
         if ($urandom_range(0, 199) == 0) rc = ~rc;
         if ($urandom_range(0, 49) == 0)
            rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 2));
         rt = ($urandom_range(0, 1) == 1);
         step(rt, rs, rp, rc, rl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
